bcd_addsub_seq: RTL
===================

# bcd_addsub_seq

Multi-cycle, parametrised BCD floating-point add/subtract unit for the calculator datapath. It supersedes the fixed-width, purely behavioural add/sub with a synthesisable, digit-serial engine. The engine has configurable digit count and exponent range, valid/ready handshakes on both sides, explicit ten's-complement subtraction, and overflow/error signalling. It sits between the keypad/operand registers and the result register, alongside the other ALU units.

## Interface

- NumDigits, default 8: significand length in BCD digits (≥2).
- MaxExp, default 7: largest legal exponent; ExpW = $clog2(MaxExp+1).
- NumW (derived) = 2 + 4*NumDigits + ExpW. Operand layout MSB→LSB: {error, sign, digit[NumDigits-1]…digit[0], exponent}.
- Value of an operand = (−1)^sign × significand × 10^exponent.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- in_valid_i  in  1  operands/op valid.
- in_ready_o  out  1  unit can accept.
- op_i  in  1  0 = a+b, 1 = a−b.
- a_i  in  NumW  left operand.
- b_i  in  NumW  right operand.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- result_o  out  NumW  result (same layout).

## Operation

- States: IDLE, ALIGN, ADD, NEG, NORM, DONE.
- IDLE: in_ready_o=1. A transfer (in_valid_i & in_ready_o) latches a, b, and op, then goes to ALIGN. Effective subtract: sub = a.sign ^ b.sign ^ op.
- Error short-cut: if a.error or b.error, go directly to DONE with result = {error=1, all other fields 0}.
- ALIGN: each cycle, shift the operand with the smaller exponent right by one digit (the LSD is dropped, i.e. truncated) and increment its exponent. Stay until the exponents are equal. The state is skipped when they are already equal.
- ADD: NumDigits cycles, one digit per cycle, LSD first.
  - Per digit: s = a_d + b'_d + c, where b'_d = b_d when sub=0, else 9−b_d. Initial c = sub.
  - If s>9: s −= 10 and c = 1; otherwise c = 0.
- After ADD:
  - sub=0 and carry out = 1: magnitude overflow. Go to NORM with a pending right shift.
  - sub=1 and carry out = 0: |a|<|b|. Go to NEG; result sign = ~a.sign.
  - sub=1 and carry out = 1: result sign = a.sign.
  - sub=0: result sign = a.sign.
- NEG: NumDigits cycles, LSD first. Computes the ten's complement of the accumulator (9−d plus an initial carry of 1).
- NORM, one action per cycle:
  - Pending right shift: shift right one digit, insert 1 at the MSD, exponent+1. If the exponent was already MaxExp, go to DONE with the error result.
  - Otherwise, while exponent≠0 and MSD==0: shift left one digit, exponent−1.
  - The state is skipped if no action is required.
- Zero result: sign forced to 0. The exponent normalises to 0 through the rule above.
- DONE: out_valid_o=1 and result_o stable until out_ready_i. On the handshake, return to IDLE. A new operand is never accepted in the same cycle as the result handshake.

## Timing

- Reset values: in_ready_o=1, out_valid_o=0, result_o=0, state=IDLE.
- Reset mid-operation: abort within the cycle. No output transfer occurs afterwards, and the next cycle behaves as post-reset.
- Latency from the accepting edge to out_valid_o: d + NumDigits + n·NumDigits + k + 1.
  - d = |a.exp−b.exp|.
  - n = 1 if NEG is used, else 0.
  - k = number of NORM actions.
  - Error short-cut latency is 1.
- in_ready_o is low from the cycle after accept until the cycle after the result handshake.
- Back-pressure: result_o and out_valid_o hold indefinitely while out_ready_i=0.
- result_o is registered; there is no combinational path from inputs to outputs.

## Test plan

Parameters are NumDigits=8, MaxExp=7. Operands are written as significand e exponent.

- 12345678e0 + 00000001e0 → +12345679e0, error=0, out_valid 9 cycles after accept.
- 99999999e0 + 00000001e0 → +10000000e1 (carry, one NORM right shift), latency 10.
- 00000005e0 − 00000007e0 → −00000002e0 via the NEG pass, latency 17. Repeat with out_ready_i held low for 5 cycles: result_o holds and in_ready_o stays 0.
- 12345678e2 + 12345678e0 → b aligned to 00123456e2, sum +12469134e2, latency 11.
- 10000000e3 − 99999990e2 → align gives 09999999e3, difference 00000001e3, three left shifts to +00001000e0, latency 13. Also 5e0 − 5e0 → +00000000e0, sign 0.
- 99999999e7 + 00000001e7 → error=1, all other fields 0. Any input with error=1 → the same error result at latency 1. Assert rst_i during ADD → out_valid_o stays 0, in_ready_o=1 the next cycle.

Source files
------------

// File: rtl/bcd_addsub_seq_if.sv
// Operand request / result response bundle for the digit-serial BCD add/sub unit.
interface bcd_addsub_seq_if #(
   parameter int unsigned NumDigits = 8,
   parameter int unsigned MaxExp    = 7
);
   localparam int unsigned ExpW = $clog2(MaxExp + 1);
   localparam int unsigned NumW = 2 + 4 * NumDigits + ExpW;

   logic            in_valid_i;
   logic            in_ready_o;
   logic            op_i;
   logic [NumW-1:0] a_i;
   logic [NumW-1:0] b_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [NumW-1:0] result_o;

   modport master (
      output in_valid_i, op_i, a_i, b_i, out_ready_i,
      input  in_ready_o, out_valid_o, result_o
   );

   modport slave (
      input  in_valid_i, op_i, a_i, b_i, out_ready_i,
      output in_ready_o, out_valid_o, result_o
   );
endinterface

// File: rtl/bcd_addsub_seq.sv
// Digit-serial BCD floating-point add/subtract: align, LSD-first add, optional
// ten's-complement pass, normalise, then hold the result until it is taken.
module bcd_addsub_seq #(
   parameter int unsigned NumDigits = 8,
   parameter int unsigned MaxExp    = 7
) (
   input logic             clk_i,
   input logic             rst_i,
   bcd_addsub_seq_if.slave bus
);
   localparam int unsigned ExpW = $clog2(MaxExp + 1);
   localparam int unsigned SigW = 4 * NumDigits;
   localparam int unsigned NumW = 2 + SigW + ExpW;
   localparam int unsigned CntW = $clog2(NumDigits);

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NEG, NORM, DONE} state_t;

   state_t          state;
   logic [SigW-1:0] a_sig;
   logic [SigW-1:0] b_sig;
   logic [SigW-1:0] acc;
   logic [ExpW-1:0] exp_a;
   logic [ExpW-1:0] exp_b;
   logic [CntW-1:0] cnt;
   logic            sub;
   logic            a_sign;
   logic            res_sign;
   logic            carry;
   logic            ovf;
   logic            err;
   logic            in_ready;
   logic            out_valid;
   logic [NumW-1:0] result;

   logic [3:0] lhs;
   logic [3:0] rhs;
   logic [3:0] rhs_eff;
   logic [4:0] step_sum;
   logic [3:0] step_digit;
   logic       step_carry;
   logic       last_digit;
   logic       need_left;
   logic       norm_more;

   // One shared digit adder: ADD uses a + b' + c, NEG uses 0 + (9 - acc) + c.
   always_comb begin
      lhs        = (state == NEG) ? 4'd0 : a_sig[3:0];
      rhs        = (state == NEG) ? acc[3:0] : b_sig[3:0];
      rhs_eff    = ((state == NEG) || sub) ? 4'(4'd9 - rhs) : rhs;
      step_sum   = 5'(lhs) + 5'(rhs_eff) + 5'(carry);
      step_carry = (step_sum > 5'd9);
      step_digit = step_carry ? 4'(step_sum - 5'd10) : step_sum[3:0];
   end

   assign last_digit = (cnt == CntW'(NumDigits - 1));
   // MSD after the final ADD/NEG step is the digit being shifted in right now.
   assign need_left  = (exp_a != '0) && (step_digit == 4'd0);
   assign norm_more  = (exp_a != ExpW'(1)) && (acc[SigW-5 -: 4] == 4'd0);

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = out_valid;
   assign bus.result_o    = result;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         a_sig     <= '0;
         b_sig     <= '0;
         acc       <= '0;
         exp_a     <= '0;
         exp_b     <= '0;
         cnt       <= '0;
         sub       <= 1'b0;
         a_sign    <= 1'b0;
         res_sign  <= 1'b0;
         carry     <= 1'b0;
         ovf       <= 1'b0;
         err       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid_i && in_ready) begin
                  a_sig    <= bus.a_i[NumW-3:ExpW];
                  b_sig    <= bus.b_i[NumW-3:ExpW];
                  exp_a    <= bus.a_i[ExpW-1:0];
                  exp_b    <= bus.b_i[ExpW-1:0];
                  a_sign   <= bus.a_i[NumW-2];
                  sub      <= bus.a_i[NumW-2] ^ bus.b_i[NumW-2] ^ bus.op_i;
                  carry    <= bus.a_i[NumW-2] ^ bus.b_i[NumW-2] ^ bus.op_i;
                  acc      <= '0;
                  cnt      <= '0;
                  ovf      <= 1'b0;
                  err      <= 1'b0;
                  in_ready <= 1'b0;
                  if (bus.a_i[NumW-1] || bus.b_i[NumW-1]) begin
                     err   <= 1'b1;
                     state <= DONE;
                  end else if (bus.a_i[ExpW-1:0] == bus.b_i[ExpW-1:0]) begin
                     state <= ADD;
                  end else begin
                     state <= ALIGN;
                  end
               end
            end

            ALIGN: begin
               if (exp_a < exp_b) begin
                  a_sig <= {4'd0, a_sig[SigW-1:4]};
                  exp_a <= exp_a + ExpW'(1);
                  if ((exp_a + ExpW'(1)) == exp_b) state <= ADD;
               end else begin
                  b_sig <= {4'd0, b_sig[SigW-1:4]};
                  exp_b <= exp_b + ExpW'(1);
                  if ((exp_b + ExpW'(1)) == exp_a) state <= ADD;
               end
            end

            ADD: begin
               acc   <= {step_digit, acc[SigW-1:4]};
               a_sig <= {4'd0, a_sig[SigW-1:4]};
               b_sig <= {4'd0, b_sig[SigW-1:4]};
               carry <= step_carry;
               cnt   <= cnt + CntW'(1);
               if (last_digit) begin
                  cnt <= '0;
                  if (!sub && step_carry) begin
                     ovf      <= 1'b1;
                     res_sign <= a_sign;
                     state    <= NORM;
                  end else if (sub && !step_carry) begin
                     // |a| < |b|: accumulator holds 10^N - (|b|-|a|)
                     res_sign <= ~a_sign;
                     carry    <= 1'b1;
                     state    <= NEG;
                  end else begin
                     res_sign <= a_sign;
                     state    <= need_left ? NORM : DONE;
                  end
               end
            end

            NEG: begin
               acc   <= {step_digit, acc[SigW-1:4]};
               carry <= step_carry;
               cnt   <= cnt + CntW'(1);
               if (last_digit) begin
                  cnt   <= '0;
                  state <= need_left ? NORM : DONE;
               end
            end

            NORM: begin
               if (ovf) begin
                  ovf <= 1'b0;
                  if (exp_a == ExpW'(MaxExp)) begin
                     err <= 1'b1;
                  end else begin
                     acc   <= {4'd1, acc[SigW-1:4]};
                     exp_a <= exp_a + ExpW'(1);
                  end
                  state <= DONE;
               end else begin
                  acc   <= {acc[SigW-5:0], 4'd0};
                  exp_a <= exp_a - ExpW'(1);
                  if (!norm_more) state <= DONE;
               end
            end

            DONE: begin
               // First DONE cycle loads the result; later cycles wait for the consumer.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  if (err) result <= {1'b1, {(NumW-1){1'b0}}};
                  else     result <= {1'b0, res_sign & (acc != '0), acc, exp_a};
               end else if (bus.out_ready_i) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule
